// File: rtl/io_undd.sv
// Peripheral side of the in/out handshake: button debounce, switch capture with
// a one-cycle enter pulse, and a held display register for out.
module io_undd #(
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          SIGN_EXT        = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  botao,
    input  logic [SW_WIDTH-1:0]   chaves,
    input  logic                  aguardando,
    input  logic                  controleOUT,
    input  logic [DATA_WIDTH-1:0] dado_out_cpu,
    output logic                  enter,
    output logic [DATA_WIDTH-1:0] dado_in,
    output logic [DATA_WIDTH-1:0] display,
    output logic                  out_valid,
    output logic                  led_espera
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] HI_MASK = ~DATA_WIDTH'({SW_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PULSE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  capture;
    logic                  botao_meta;
    logic                  botao_sync;
    logic [SW_WIDTH-1:0]   chaves_meta;
    logic [SW_WIDTH-1:0]   chaves_sync;
    logic                  deb;
    logic [CNT_W-1:0]      deb_cnt;
    logic [DATA_WIDTH-1:0] sw_ext;

    // Two-flop synchronisers for the asynchronous button and switches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            botao_meta  <= 1'b0;
            botao_sync  <= 1'b0;
            chaves_meta <= '0;
            chaves_sync <= '0;
        end else begin
            botao_meta  <= botao;
            botao_sync  <= botao_meta;
            chaves_meta <= chaves;
            chaves_sync <= chaves_meta;
        end
    end

    // Level changes only after DEBOUNCE_CYCLES consecutive mismatching samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (botao_sync != deb) begin
            if (deb_cnt == CNT_LAST) begin
                deb     <= ~deb;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    always_comb begin
        sw_ext = DATA_WIDTH'(chaves_sync);
        if (SIGN_EXT && chaves_sync[SW_WIDTH-1]) begin
            sw_ext = sw_ext | HI_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arming only from a released button keeps a held press from counting twice
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (aguardando && !deb) state_nxt = ARMED;
            end
            ARMED: begin
                if (!aguardando) begin
                    state_nxt = IDLE;
                end else if (deb) begin
                    state_nxt = PULSE;
                    capture   = 1'b1;
                end
            end
            PULSE:   state_nxt = RELEASE;
            RELEASE: begin
                if (!deb) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs registered from the next state so they align with the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter      <= 1'b0;
            led_espera <= 1'b0;
            dado_in    <= '0;
        end else begin
            enter      <= (state_nxt == PULSE);
            led_espera <= (state_nxt == ARMED);
            if (capture) dado_in <= sw_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            display   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= controleOUT;
            if (controleOUT) display <= dado_out_cpu;
        end
    end

endmodule

// File: doc/io_undd.md
Name: io_undd

Overview:
- Peripheral side of the processor's `in`/`out` instruction handshake.
- For `in`: while the control unit waits for input, the block debounces the physical confirm button and latches the switch value. It then returns a single-cycle `enter` pulse with stable data for the register-write path.
- For `out`: it latches the register value presented with `controleOUT` into a held display register.

Parameters:
- SW_WIDTH, 16: width of the switch bank.
- DATA_WIDTH, 32: processor word width; must be ≥ SW_WIDTH.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level change; must be ≥ 2.
- SIGN_EXT, 0: 1 = sign-extend switches to DATA_WIDTH; 0 = zero-extend.

Ports:
- clk, input, 1: single system clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset.
- botao, input, 1: raw confirm pushbutton; asynchronous, active-high, bouncing.
- chaves, input, SW_WIDTH: raw switch bank; asynchronous.
- aguardando, input, 1: high while the control unit sits in its wait-for-input state.
- controleOUT, input, 1: output strobe from the control unit.
- dado_out_cpu, input, DATA_WIDTH: register value to be displayed.
- enter, output, 1: input-accepted pulse to the control unit.
- dado_in, output, DATA_WIDTH: captured, extended switch value for the register write mux.
- display, output, DATA_WIDTH: latched output value.
- out_valid, output, 1: one-cycle pulse when display updates.
- led_espera, output, 1: high while armed and waiting for a press.

Behaviour:
- Reset (reset=0, async): every register clears.
  - State = IDLE.
  - Sync flops, debounced level `deb` and debounce counter = 0.
  - enter, dado_in, display, out_valid, led_espera = 0.
  - Reset mid-operation aborts any pending capture. No enter is issued after release.
- Synchronisers:
  - botao passes through 2 flops.
  - chaves passes through 2 flops (per bit).
  - Only synchronised copies are used downstream.
- Debounce:
  - Counter increments each posedge while sync_botao != deb.
  - Counter clears whenever they agree.
  - When the mismatch has been seen on DEBOUNCE_CYCLES consecutive posedges, deb toggles and the counter clears.
  - Any agreement (bounce) restarts the count.
- Input FSM (Moore):
  - IDLE: if aguardando=1 and deb=0, go to ARMED. A button already held never counts as a press.
  - ARMED: led_espera=1.
    - If aguardando=0, go to IDLE; no pulse.
    - Else if deb=1, go to PULSE and capture dado_in ← extend(sync_chaves).
  - PULSE: enter=1 for exactly one cycle, then unconditionally go to RELEASE.
  - RELEASE: stay until deb=0, then go to IDLE. One held press can never satisfy two consecutive `in` instructions.
- Input latency: if botao is first sampled high at posedge k and stays clean, enter is high during the cycle following posedge k+DEBOUNCE_CYCLES+2.
- enter width: the one-cycle enter spans a negedge, so the control unit (negedge-sampled) sees it exactly once.
- dado_in hold: dado_in holds from capture until the next capture. It is stable through the control unit's register-write state.
- Extension: SIGN_EXT=1 replicates chaves MSB into the upper DATA_WIDTH-SW_WIDTH bits; otherwise they are zero.
- Output path: at a posedge with controleOUT=1, display ← dado_out_cpu and out_valid=1 for that following cycle. Otherwise display holds and out_valid=0.
- Back-to-back strobes: controleOUT high on consecutive cycles updates display each cycle and keeps out_valid high.
- Independence: input and output paths are independent. A simultaneous strobe and capture both take effect in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Clean press:
  - Stimulus: reset, aguardando=1, chaves=16'h00A5; botao rises before posedge k and is held 12 cycles.
  - Required: enter high only in the cycle after posedge k+6; dado_in=32'h000000A5; led_espera 1→0 at PULSE.
- Bounce:
  - Stimulus: botao toggles every 2 cycles for 30 cycles with aguardando=1.
  - Required: deb stays 0, enter never asserts, state remains ARMED.
- Held button:
  - Stimulus: botao debounced high before aguardando rises.
  - Required: no enter; after ≥4 low cycles and a new 6-cycle press, exactly one enter pulse.
- Sign extension:
  - Stimulus: SIGN_EXT=1, chaves=16'h8001, clean press.
  - Required: dado_in=32'hFFFF8001. With SIGN_EXT=0: 32'h00008001.
- Output strobe:
  - Stimulus: controleOUT high one cycle with dado_out_cpu=32'hDEADBEEF, then dado_out_cpu changes.
  - Required: display=32'hDEADBEEF after that posedge and held; out_valid high exactly one cycle.
- Abort cases:
  - Stimulus: aguardando drops in ARMED before deb rises.
  - Required: return to IDLE with no enter.
  - Stimulus: reset driven low mid-PULSE.
  - Required: enter, dado_in and display go to 0 immediately without a clock edge.
